// File: rtl/fetch_sequencer_if.sv
// Fetch/issue bus between fetch_sequencer and its memory, decode and execute neighbours.
// The master modport is the sequencer side.
interface fetch_sequencer_if #(
  parameter int unsigned PC_W = 32
);
  logic            imem_req;
  logic [PC_W-1:0] imem_addr;
  logic            imem_ready;
  logic [PC_W-1:0] imem_rdata;
  logic [PC_W-1:0] instr_out;
  logic            instr_valid;
  logic            instr_accept;
  logic            ex_done;
  logic            branch_taken;
  logic [PC_W-1:0] branch_target;

  modport master (
    output imem_req, imem_addr, instr_out, instr_valid,
    input  imem_ready, imem_rdata, instr_accept, ex_done, branch_taken, branch_target
  );

  modport slave (
    input  imem_req, imem_addr, instr_out, instr_valid,
    output imem_ready, imem_rdata, instr_accept, ex_done, branch_taken, branch_target
  );
endinterface

// File: rtl/fetch_sequencer.sv
// Multi-cycle PC / instruction-fetch controller: fetch, issue, wait for execute, pick next PC.
// Detects HALT, flags misaligned taken targets, counts retired instructions.
module fetch_sequencer #(
  parameter int unsigned     PC_W        = 32,
  parameter logic [PC_W-1:0] RESET_PC    = '0,
  parameter int unsigned     PC_STEP     = 4,
  parameter logic [5:0]      HALT_OPCODE = 6'b111111
) (
  input  logic                   clk,
  input  logic                   rst_n,
  fetch_sequencer_if.master      bus,
  output logic [PC_W-1:0]        pc,
  output logic                   halted,
  output logic                   misaligned,
  output logic [31:0]            retired_count
);

  localparam logic [2:0] S_IDLE   = 3'd0;
  localparam logic [2:0] S_FETCH  = 3'd1;
  localparam logic [2:0] S_ISSUE  = 3'd2;
  localparam logic [2:0] S_EXEC   = 3'd3;
  localparam logic [2:0] S_HALTED = 3'd4;

  logic [2:0]      state;
  logic            req_q;
  logic            valid_q;
  logic [PC_W-1:0] instr_q;

  // The fetch address is the PC register itself, so it is stable while req is held.
  assign bus.imem_req    = req_q;
  assign bus.imem_addr   = pc;
  assign bus.instr_out   = instr_q;
  assign bus.instr_valid = valid_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state         <= S_IDLE;
      pc            <= RESET_PC;
      req_q         <= 1'b0;
      valid_q       <= 1'b0;
      instr_q       <= '0;
      halted        <= 1'b0;
      misaligned    <= 1'b0;
      retired_count <= '0;
    end else begin
      case (state)
        S_IDLE: begin
          req_q <= 1'b1;
          state <= S_FETCH;
        end
        S_FETCH: begin
          if (bus.imem_ready) begin
            instr_q <= bus.imem_rdata;
            req_q   <= 1'b0;
            valid_q <= 1'b1;
            state   <= S_ISSUE;
          end
        end
        S_ISSUE: begin
          if (bus.instr_accept) begin
            valid_q <= 1'b0;
            // HALT retires on acceptance; it never reaches execute.
            if (instr_q[31:26] == HALT_OPCODE) begin
              halted        <= 1'b1;
              retired_count <= retired_count + 32'd1;
              state         <= S_HALTED;
            end else begin
              state <= S_EXEC;
            end
          end
        end
        S_EXEC: begin
          if (bus.ex_done) begin
            retired_count <= retired_count + 32'd1;
            if (bus.branch_taken) begin
              pc <= {bus.branch_target[PC_W-1:2], 2'b00};
              if (bus.branch_target[1:0] != 2'b00) begin
                misaligned <= 1'b1;
              end
            end else begin
              pc <= pc + PC_W'(PC_STEP);
            end
            req_q <= 1'b1;
            state <= S_FETCH;
          end
        end
        S_HALTED: begin
          req_q   <= 1'b0;
          valid_q <= 1'b0;
        end
        default: begin
          req_q   <= 1'b0;
          valid_q <= 1'b0;
          state   <= S_IDLE;
        end
      endcase
    end
  end

endmodule
